// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block.
// Holds the FSM state encoding and the synchronizer depth floor.
package pwm_capture_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // Fewer than two flops leaves too little metastability settling time.
    localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/pwm_capture_if.sv
// Capture-side signal bundle: enable and raw PWM in, measurement results out.
// The slave modport is the capture block; the master modport is its driver/consumer.
interface pwm_capture_if #(
    parameter int WIDTH = 8
);

    logic             en;
    logic             pwm_in;
    logic [WIDTH-1:0] high_o;
    logic [WIDTH-1:0] period_o;
    logic             valid_o;
    logic             overflow_o;

    modport master (
        output en,
        output pwm_in,
        input  high_o,
        input  period_o,
        input  valid_o,
        input  overflow_o
    );

    modport slave (
        input  en,
        input  pwm_in,
        output high_o,
        output period_o,
        output valid_o,
        output overflow_o
    );

endinterface

// File: rtl/pwm_capture_sync_edge.sv
// Synchronizes the asynchronous PWM input and flags its rising and falling edges.
// The synchronizer and edge flops run regardless of enable so edges stay coherent.
module sync_edge
    import pwm_capture_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

    logic [STAGES-1:0] sync_r;
    logic              prev_r;
    logic              sync_s;

    assign sync_s = sync_r[STAGES-1];

    // Synchronizer shift chain followed by the previous-value flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {STAGES{1'b0}};
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], din};
            prev_r <= sync_s;
        end
    end

    assign rise = sync_s & ~prev_r;
    assign fall = ~sync_s & prev_r;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an external PWM waveform in clk cycles.
// Each completed period, or a stuck-level timeout, is published with a one-cycle strobe.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    pwm_capture_if.slave bus
);

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (v == CNT_MAX) begin
            r = CNT_MAX;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] pcnt_r;
    logic [WIDTH-1:0] hcnt_r;
    logic [WIDTH-1:0] high_r;
    logic [WIDTH-1:0] period_r;
    logic             valid_r;
    logic             overflow_r;

    logic             rise_s;
    logic             fall_s;
    logic             timeout_s;

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (bus.pwm_in),
        .rise  (rise_s),
        .fall  (fall_s)
    );

    // A rise landing on the saturation cycle is still a valid measurement.
    assign timeout_s = (pcnt_r == CNT_MAX) && !rise_s;

    // Measurement FSM, counters and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            pcnt_r     <= CNT_ZERO;
            hcnt_r     <= CNT_ZERO;
            high_r     <= CNT_ZERO;
            period_r   <= CNT_ZERO;
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else if (!bus.en) begin
            state_r <= IDLE;
            pcnt_r  <= CNT_ZERO;
            hcnt_r  <= CNT_ZERO;
            valid_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (rise_s) begin
                        state_r <= HIGH;
                        pcnt_r  <= CNT_ONE;
                        hcnt_r  <= CNT_ONE;
                    end
                end
                HIGH: begin
                    if (timeout_s) begin
                        high_r     <= CNT_MAX;
                        period_r   <= CNT_MAX;
                        overflow_r <= 1'b1;
                        valid_r    <= 1'b1;
                        pcnt_r     <= CNT_ZERO;
                        hcnt_r     <= CNT_ZERO;
                        state_r    <= IDLE;
                    end else begin
                        pcnt_r <= sat_inc(pcnt_r);
                        if (fall_s) begin
                            state_r <= LOW;
                        end else begin
                            hcnt_r <= sat_inc(hcnt_r);
                        end
                    end
                end
                LOW: begin
                    if (rise_s) begin
                        high_r     <= hcnt_r;
                        period_r   <= pcnt_r;
                        overflow_r <= 1'b0;
                        valid_r    <= 1'b1;
                        pcnt_r     <= CNT_ONE;
                        hcnt_r     <= CNT_ONE;
                        state_r    <= HIGH;
                    end else if (timeout_s) begin
                        high_r     <= CNT_ZERO;
                        period_r   <= CNT_MAX;
                        overflow_r <= 1'b1;
                        valid_r    <= 1'b1;
                        pcnt_r     <= CNT_ZERO;
                        hcnt_r     <= CNT_ZERO;
                        state_r    <= IDLE;
                    end else begin
                        pcnt_r <= sat_inc(pcnt_r);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    pcnt_r  <= CNT_ZERO;
                    hcnt_r  <= CNT_ZERO;
                end
            endcase
        end
    end

    assign bus.high_o     = high_r;
    assign bus.period_o   = period_r;
    assign bus.valid_o    = valid_r;
    assign bus.overflow_o = overflow_r;

endmodule
